autotype_sequencer: RTL

- Scripted keystroke scheduler for the Orao top level on boards without buttons.
- Drives the computer's n_reset, key_b, key_c and key_enter inputs from a small parameter-defined script of timed steps, e.g. reset, B, C, ENTER, ENTER, ENTER to enter BASIC.
- Physical keyboard activity aborts the script and hands control back to the user.
- Replaces a free-running counter decode with an explicit, restartable state machine.

---
 rtl/autotype_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/autotype_sequencer.sv
// Scripted keystroke scheduler: plays a parameter-defined script of reset pulses, key
// presses and waits into the computer's inputs; any physical key aborts it.
module autotype_sequencer #(
   parameter int                 TICK_DIV    = 25000,
   parameter int unsigned        RESET_TICKS = 500,
   parameter int unsigned        PRESS_TICKS = 100,
   parameter int unsigned        GAP_TICKS   = 400,
   parameter int unsigned        STEPS       = 8,
   parameter logic [4*STEPS-1:0] SCRIPT      = 32'h0AAA_E984,
   parameter bit                 AUTOSTART   = 1'b1,
   localparam int unsigned       IdxW        = (STEPS > 1) ? $clog2(STEPS) : 1
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic            user_key_any_i,
   output logic            n_reset_out_o,
   output logic            key_b_o,
   output logic            key_c_o,
   output logic            key_enter_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [IdxW-1:0] step_idx_o
);

   localparam int unsigned TdEff    = (TICK_DIV < 1) ? 1 : TICK_DIV;
   localparam int unsigned ResetT   = (RESET_TICKS == 0) ? 1 : RESET_TICKS;
   localparam int unsigned PressT   = (PRESS_TICKS == 0) ? 1 : PRESS_TICKS;
   localparam int unsigned GapT     = (GAP_TICKS == 0) ? 1 : GAP_TICKS;
   localparam int unsigned WaitMax  = 4 * GapT;
   localparam int unsigned Max1     = (ResetT > PressT) ? ResetT : PressT;
   localparam int unsigned TimerMax = (Max1 > WaitMax) ? Max1 : WaitMax;
   localparam int unsigned TimerW   = $clog2(TimerMax + 1);
   localparam int unsigned PreW     = (TdEff > 1) ? $clog2(TdEff) : 1;

   localparam logic [1:0] OpEnd   = 2'b00;
   localparam logic [1:0] OpReset = 2'b01;
   localparam logic [1:0] OpKey   = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StResetHold,
      StPress,
      StGap,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   step_q, step_d;
   logic              past_end_q, past_end_d;
   logic [PreW-1:0]   presc_q, presc_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              n_reset_q, n_reset_d;
   logic              key_b_q, key_b_d;
   logic              key_c_q, key_c_d;
   logic              key_enter_q, key_enter_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [3:0] step_code;
   logic [1:0] op;
   logic [1:0] arg;
   logic       tick;
   logic       expire;

   assign step_code = SCRIPT[{step_q, 2'b00} +: 4];
   assign op        = step_code[3:2];
   assign arg       = step_code[1:0];
   assign tick      = (presc_q == PreW'(TdEff - 1));
   assign expire    = tick && (timer_q == TimerW'(1));

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      past_end_d = past_end_q;
      presc_d    = presc_q;
      timer_d    = timer_q;

      if (state_q inside {StResetHold, StPress, StGap}) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (tick) begin
            timer_d = timer_q - 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (AUTOSTART || start_i) begin
               state_d    = StFetch;
               step_d     = '0;
               past_end_d = 1'b0;
            end
         end
         StFetch: begin
            if (user_key_any_i || past_end_q || (op == OpEnd)) begin
               state_d = StDone;
            end else begin
               presc_d = '0;
               case (op)
                  OpReset: begin
                     state_d = StResetHold;
                     timer_d = TimerW'(ResetT);
                  end
                  OpKey: begin
                     state_d = StPress;
                     timer_d = TimerW'(PressT);
                  end
                  default: begin
                     state_d = StGap;
                     timer_d = TimerW'((32'(arg) + 32'd1) * GapT);
                  end
               endcase
            end
         end
         StResetHold, StPress: begin
            // Abort wins over a timer expiring in the same cycle.
            if (user_key_any_i) begin
               state_d = StDone;
            end else if (expire) begin
               state_d = StGap;
               presc_d = '0;
               timer_d = TimerW'(GapT);
            end
         end
         StGap: begin
            if (user_key_any_i) begin
               state_d = StDone;
            end else if (expire) begin
               state_d = StFetch;
               // Running off the end of the script latches a flag instead of wrapping.
               if (step_q == IdxW'(STEPS - 1)) begin
                  past_end_d = 1'b1;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         StDone: begin
            if (start_i) begin
               state_d    = StFetch;
               step_d     = '0;
               past_end_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so they leave the flops aligned with it.
   always_comb begin
      n_reset_d   = 1'b1;
      key_b_d     = 1'b0;
      key_c_d     = 1'b0;
      key_enter_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      unique case (state_d)
         StFetch: begin
            busy_d = 1'b1;
            if (state_q == StIdle) begin
               n_reset_d = n_reset_q;
            end
         end
         StResetHold: begin
            busy_d    = 1'b1;
            n_reset_d = 1'b0;
         end
         StPress: begin
            busy_d      = 1'b1;
            key_b_d     = (arg == 2'd0);
            key_c_d     = (arg == 2'd1);
            key_enter_d = (arg == 2'd2);
         end
         StGap:   busy_d = 1'b1;
         StDone:  done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         step_q      <= '0;
         past_end_q  <= 1'b0;
         presc_q     <= '0;
         timer_q     <= '0;
         n_reset_q   <= 1'b0;
         key_b_q     <= 1'b0;
         key_c_q     <= 1'b0;
         key_enter_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         past_end_q  <= past_end_d;
         presc_q     <= presc_d;
         timer_q     <= timer_d;
         n_reset_q   <= n_reset_d;
         key_b_q     <= key_b_d;
         key_c_q     <= key_c_d;
         key_enter_q <= key_enter_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign n_reset_out_o = n_reset_q;
   assign key_b_o       = key_b_q;
   assign key_c_o       = key_c_q;
   assign key_enter_o   = key_enter_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign step_idx_o    = step_q;

endmodule
